// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: N source streams in, one arbitrated stream out, plus grant status.
// slave is the arbiter's view; master is the surrounding fabric (sources and sink).
// With STREAM_RR_ARBITER_LAST_EN defined, a per-source last input and a registered
// last output are added.
interface stream_rr_arbiter_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
);
  logic [N*DW-1:0] stream_s_data_i;
  logic [N-1:0]    stream_s_valid_i;
  logic [N-1:0]    stream_s_ready_o;
  logic [DW-1:0]   stream_m_data_o;
  logic            stream_m_valid_o;
  logic            stream_m_ready_i;
  logic [N-1:0]    grant_o;
  logic [IW-1:0]   grant_id_o;
`ifdef STREAM_RR_ARBITER_LAST_EN
  logic [N-1:0]    stream_s_last_i;
  logic            stream_m_last_o;

  modport slave (
    input  stream_s_data_i, stream_s_valid_i, stream_s_last_i, stream_m_ready_i,
    output stream_s_ready_o, stream_m_data_o, stream_m_valid_o, stream_m_last_o,
    output grant_o, grant_id_o
  );

  modport master (
    output stream_s_data_i, stream_s_valid_i, stream_s_last_i, stream_m_ready_i,
    input  stream_s_ready_o, stream_m_data_o, stream_m_valid_o, stream_m_last_o,
    input  grant_o, grant_id_o
  );
`else
  modport slave (
    input  stream_s_data_i, stream_s_valid_i, stream_m_ready_i,
    output stream_s_ready_o, stream_m_data_o, stream_m_valid_o,
    output grant_o, grant_id_o
  );

  modport master (
    output stream_s_data_i, stream_s_valid_i, stream_m_ready_i,
    input  stream_s_ready_o, stream_m_data_o, stream_m_valid_o,
    input  grant_o, grant_id_o
  );
`endif
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N:1 valid/ready arbiter with bounded bursts and a
// registered output stage. Every change of owner passes through one IDLE cycle.
// Optional macro STREAM_RR_ARBITER_LAST_EN: grants end on a transfer carrying last
// (or on valid dropping) instead of at the BURST limit, so packets never interleave.
module stream_rr_arbiter #(
  parameter int unsigned DW    = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 8,
  parameter int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  stream_rr_arbiter_if.slave arb
);

  localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gid_q;
  logic [N-1:0]  grant_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] m_data_q;
  logic          m_valid_q;

  logic          slot_free;
  logic          own_valid;
  logic [DW-1:0] own_data;
  logic          xfer;
  logic          burst_end;
  logic          release_c;
  logic          lo_any;
  logic          hi_any;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_d;

  assign slot_free = !m_valid_q || arb.stream_m_ready_i;
  assign own_valid = |(arb.stream_s_valid_i & grant_q);
  assign xfer      = (state_q == GRANT) && own_valid && slot_free;
  assign release_c = (state_q == GRANT) && (!own_valid || (xfer && burst_end));
  assign sel_idx   = hi_any ? hi_idx : lo_idx;
  assign ptr_d     = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;

`ifdef STREAM_RR_ARBITER_LAST_EN
  logic own_last;
  logic m_last_q;

  assign own_last  = |(arb.stream_s_last_i & grant_q);
  assign burst_end = own_last;
  assign arb.stream_m_last_o = m_last_q;
`else
  assign burst_end = (cnt_q == CW'(BURST - 1));
`endif

  assign arb.stream_s_ready_o = ((state_q == GRANT) && slot_free) ? grant_q : '0;
  assign arb.stream_m_data_o  = m_data_q;
  assign arb.stream_m_valid_o = m_valid_q;
  assign arb.grant_o          = grant_q;
  assign arb.grant_id_o       = gid_q;

  // Mux the current owner's data (grant_q is one-hot or zero).
  always_comb begin
    own_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_q[i]) begin
        own_data = arb.stream_s_data_i[i*DW +: DW];
      end
    end
  end

  // Pick the first requester at or above ptr; fall back to the lowest requester (wrap).
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    hi_any = 1'b0;
    hi_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (arb.stream_s_valid_i[i]) begin
        lo_any = 1'b1;
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_any = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  // Grant FSM: owner selection, burst counting, release and pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lo_any) begin
            state_q <= GRANT;
            grant_q <= N'(1) << sel_idx;
            gid_q   <= sel_idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (release_c) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output slice: load on a source transfer, drain when the sink accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
`ifdef STREAM_RR_ARBITER_LAST_EN
      m_last_q  <= 1'b0;
`endif
    end else if (xfer) begin
      m_data_q  <= own_data;
      m_valid_q <= 1'b1;
`ifdef STREAM_RR_ARBITER_LAST_EN
      m_last_q  <= own_last;
`endif
    end else if (arb.stream_m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for stream_rr_arbiter (N=4, DW=16, BURST=8).
// Build with STREAM_RR_ARBITER_LAST_EN to run the packet-mode scenario instead of the
// BURST scenarios.
module tb_stream_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int BURST = 8;

  logic clk;
  logic rst;

  stream_rr_arbiter_if #(.DW(DW), .N(N)) bus ();

  stream_rr_arbiter #(.DW(DW), .N(N), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  int sent [N];
  int lim [N];
  int hold_at [N];
  logic [N-1:0] hold_mask;
  logic [15:0] dbase;
  logic [15:0] dtag;
  int rdy_mode;
  int cyc;
  int pat [4] = '{1, 0, 0, 1};

  logic [31:0] exp_q [$];
  int gq [$];
  int iq [$];
  int wpg [$];
  int src_cnt [16];

  logic [N-1:0] fire_s;
  logic [N-1:0] prev_grant;
  logic         prev_mvalid;
  logic         prev_mready;
  logic [15:0]  prev_mdata;
  int idle_len, cur_words, out_cnt, gap_cnt, gap_target;
  int ready_bad, gid_bad, stall_err;
  logic have_granted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word(input int i, input int n);
    return 16'(int'(dbase) + int'(dtag) * i + n);
  endfunction

  function automatic logic [31:0] exp_word(input int i, input int n, input logic last);
`ifdef STREAM_RR_ARBITER_LAST_EN
    return {15'd0, last, word(i, n)};
`else
    return {15'd0, 1'b0 & last, word(i, n)};
`endif
  endfunction

  function automatic logic cur_last();
`ifdef STREAM_RR_ARBITER_LAST_EN
    return bus.stream_m_last_o;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic all_sent();
    for (int i = 0; i < N; i++) if (sent[i] < lim[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.stream_s_valid_i[i] = (sent[i] < lim[i]) && !(hold_mask[i] && sent[i] == hold_at[i]);
      bus.stream_s_data_i[i*DW +: DW] = word(i, sent[i]);
`ifdef STREAM_RR_ARBITER_LAST_EN
      bus.stream_s_last_i[i] = (sent[i] == lim[i] - 1);
`endif
    end
    case (rdy_mode)
      0:       bus.stream_m_ready_i = 1'b1;
      1:       bus.stream_m_ready_i = (cyc < 24) ? 1'(pat[cyc % 4]) : 1'($urandom_range(0, 1));
      default: bus.stream_m_ready_i = 1'b0;
    endcase
  endtask

  // Observe one cycle (called mid-cycle, inputs and outputs stable).
  task automatic monitor();
    logic [N-1:0] g;
    logic [N-1:0] r;
    logic [N-1:0] onehot;
    logic [31:0]  got;
    g = bus.grant_o;
    r = bus.stream_s_ready_o;
    fire_s = bus.stream_s_valid_i & r;
    if ((r & ~g) != '0 || $countones(r) > 1) ready_bad++;
    if (g != '0) begin
      onehot = N'(1) << bus.grant_id_o;
      if (onehot != g) gid_bad++;
    end
    if (prev_mvalid && !prev_mready &&
        (!bus.stream_m_valid_o || bus.stream_m_data_o != prev_mdata)) stall_err++;
    if (!bus.stream_m_valid_o && out_cnt > 0 && out_cnt < gap_target) gap_cnt++;
    if (bus.stream_m_valid_o && bus.stream_m_ready_i) begin
      got = {15'd0, cur_last(), bus.stream_m_data_o};
      if (exp_q.size() == 0) check("sb_empty_pop", 32'(exp_q.size()), 1);
      else check("out_word", got, exp_q.pop_front());
      src_cnt[bus.stream_m_data_o[11:8]]++;
      out_cnt++;
    end
    if (prev_grant != '0 && g != prev_grant) begin
      wpg.push_back(cur_words);
      cur_words = 0;
    end
    if (g != '0 && g != prev_grant) begin
      gq.push_back(int'(bus.grant_id_o));
      if (prev_grant == '0 && have_granted) iq.push_back(idle_len);
      have_granted = 1'b1;
      idle_len = 0;
    end
    if (g == '0) idle_len++;
    cur_words += $countones(fire_s & g);
    prev_grant  = g;
    prev_mvalid = bus.stream_m_valid_o;
    prev_mready = bus.stream_m_ready_i;
    prev_mdata  = bus.stream_m_data_o;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire_s[i]) sent[i]++;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      lim[i] = 0;
      hold_at[i] = 0;
    end
    for (int i = 0; i < 16; i++) src_cnt[i] = 0;
    hold_mask = '0;
    rdy_mode = 0;
    cyc = 0;
    exp_q.delete();
    gq.delete();
    iq.delete();
    wpg.delete();
    fire_s = '0;
    prev_grant = '0;
    prev_mvalid = 1'b0;
    prev_mready = 1'b0;
    prev_mdata = '0;
    idle_len = 0;
    cur_words = 0;
    out_cnt = 0;
    gap_cnt = 0;
    gap_target = 0;
    have_granted = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive();
  endtask

  task automatic run_drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !all_sent()) && k < max_cyc) begin
      step();
      k++;
    end
    check("drain_pending", 32'(exp_q.size()), 0);
    repeat (4) step();
  endtask

  initial begin
    int bad;
    int k;
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_errors = 0;
    ready_bad = 0;
    gid_bad = 0;
    stall_err = 0;
    dbase = '0;
    dtag = '0;
    rdy_mode = 0;
    hold_mask = '0;
    cyc = 0;
    drive();

    // Reset values, then 20 idle cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(bus.stream_m_valid_o), 0);
    check("rst_m_data", 32'(bus.stream_m_data_o), 0);
    check("rst_s_ready", 32'(bus.stream_s_ready_o), 0);
    check("rst_grant", 32'(bus.grant_o), 0);
    check("rst_grant_id", 32'(bus.grant_id_o), 0);
    do_reset();
    repeat (20) step();
    check("idle_m_valid", 32'(bus.stream_m_valid_o), 0);
    check("idle_grant", 32'(bus.grant_o), 0);
    check("idle_s_ready", 32'(bus.stream_s_ready_o), 0);

    // Reset asserted mid-burst discards the held word at once.
    do_reset();
    dbase = 16'h7000;
    dtag = 16'h0100;
    lim[1] = 20;
    rdy_mode = 2;
    drive();
    repeat (5) step();
    @(negedge clk);
    check("held_valid", 32'(bus.stream_m_valid_o), 1);
    check("held_data", 32'(bus.stream_m_data_o), 32'(word(1, 0)));
    check("held_grant", 32'(bus.grant_o), 32'h2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.stream_m_valid_o), 0);
    check("async_rst_data", 32'(bus.stream_m_data_o), 0);
    check("async_rst_grant", 32'(bus.grant_o), 0);
    check("async_rst_ready", 32'(bus.stream_s_ready_o), 0);

`ifndef STREAM_RR_ARBITER_LAST_EN
    // Single source 2: 16 words as two bursts of 8 with one bubble.
    do_reset();
    dbase = 16'h0001;
    dtag = 16'h0000;
    lim[2] = 16;
    gap_target = 16;
    for (int n = 0; n < 16; n++) exp_q.push_back(exp_word(2, n, 1'b0));
    drive();
    run_drain(200);
    check("single_out_cnt", 32'(out_cnt), 16);
    check("single_bubbles", 32'(gap_cnt), 1);
    check("single_grants", 32'(gq.size()), 2);
    bad = 0;
    foreach (gq[j]) if (gq[j] != 2) bad++;
    check("single_grant_id", 32'(bad), 0);
    bad = 0;
    foreach (wpg[j]) if (wpg[j] != BURST) bad++;
    check("single_burst_len", 32'(bad), 0);
    check("single_idle_gap", (iq.size() > 0) ? 32'(iq[0]) : 32'hFFFF_FFFF, 1);

    // Fairness: 4 continuous sources, 320 words, order 0,1,2,3,...
    do_reset();
    dbase = 16'hA000;
    dtag = 16'h0100;
    for (int i = 0; i < N; i++) lim[i] = 80;
    for (int j = 0; j < 320; j++) exp_q.push_back(exp_word((j / 8) % 4, ((j / 8) / 4) * 8 + j % 8, 1'b0));
    drive();
    run_drain(2000);
    check("fair_grants", 32'(gq.size()), 40);
    bad = 0;
    foreach (gq[j]) if (gq[j] != j % 4) bad++;
    check("fair_order", 32'(bad), 0);
    bad = 0;
    foreach (wpg[j]) if (wpg[j] != BURST) bad++;
    check("fair_burst_len", 32'(bad), 0);
    for (int i = 0; i < N; i++) check($sformatf("fair_words_src%0d", i), 32'(src_cnt[i]), 80);

    // Backpressure: source 1 with a stalling sink.
    do_reset();
    dbase = 16'h4000;
    dtag = 16'h0100;
    lim[1] = 40;
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) exp_q.push_back(exp_word(1, n, 1'b0));
    drive();
    run_drain(1000);
    check("bp_out_cnt", 32'(out_cnt), 40);
    check("bp_grants", 32'(wpg.size()), 5);
    bad = 0;
    foreach (wpg[j]) if (wpg[j] != BURST) bad++;
    check("bp_burst_len", 32'(bad), 0);
`endif

    // Early release: source 0 drops valid after 3 words while source 3 waits.
    do_reset();
    dbase = 16'h5000;
    dtag = 16'h0100;
    lim[0] = 6;
    lim[3] = 4;
    hold_mask[0] = 1'b1;
    hold_at[0] = 3;
    for (int n = 0; n < 3; n++) exp_q.push_back(exp_word(0, n, 1'b0));
    for (int n = 0; n < 4; n++) exp_q.push_back(exp_word(3, n, n == 3));
    for (int n = 3; n < 6; n++) exp_q.push_back(exp_word(0, n, n == 5));
    drive();
    k = 0;
    while (!bus.grant_o[3] && k < 200) begin
      step();
      k++;
    end
    check("early_g3_seen", 32'(bus.grant_o[3]), 1);
    hold_mask = '0;
    drive();
    run_drain(300);
    check("early_grants", 32'(gq.size()), 3);
    if (gq.size() == 3) begin
      check("early_g0", 32'(gq[0]), 0);
      check("early_g1", 32'(gq[1]), 3);
      check("early_g2", 32'(gq[2]), 0);
    end
    check("early_idle_gap", (iq.size() > 0) ? 32'(iq[0]) : 32'hFFFF_FFFF, 1);
    check("early_words_0", (wpg.size() > 0) ? 32'(wpg[0]) : 32'hFFFF_FFFF, 3);

`ifdef STREAM_RR_ARBITER_LAST_EN
    // Packet mode: two 12-word packets stay contiguous, last on words 12 and 24.
    do_reset();
    dbase = 16'h6000;
    dtag = 16'h0100;
    lim[0] = 12;
    lim[1] = 12;
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 12; n++) exp_q.push_back(exp_word(i, n, n == 11));
    drive();
    run_drain(300);
    check("pkt_out_cnt", 32'(out_cnt), 24);
    check("pkt_grants", 32'(wpg.size()), 2);
    bad = 0;
    foreach (wpg[j]) if (wpg[j] != 12) bad++;
    check("pkt_len", 32'(bad), 0);
`endif

    check("ready_in_grant", 32'(ready_bad), 0);
    check("grant_id_match", 32'(gid_bad), 0);
    check("stall_stable", 32'(stall_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
